// File: rtl/proc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | proc_pkg: opcode, controller-state and ALU-op encodings shared by     |
// | the control unit and its testbench.                                   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package proc_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_MOV = 4'h6,
    OP_LDI = 4'h7,
    OP_JMP = 4'h8,
    OP_JZ  = 4'h9,
    OP_CMP = 4'hA,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } ctrl_state_t;

  typedef enum logic [2:0] {
    ALU_PASS_A = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_AND    = 3'd3,
    ALU_OR     = 3'd4,
    ALU_XOR    = 3'd5
  } alu_op_t;

  localparam logic [3:0] REG_PIN     = 4'd10;
  localparam logic [3:0] REG_POUT    = 4'd11;
  localparam logic [3:0] REG_RCTIMER = 4'd12;
  localparam logic [3:0] REG_TIMER   = 4'd13;
  localparam logic [3:0] REG_XH      = 4'd14;
  localparam logic [3:0] REG_XL      = 4'd15;

  // Opcodes without an ALU meaning decode to PASS_A.
  function automatic alu_op_t alu_decode(input logic [3:0] op);
    alu_op_t res;
    res = ALU_PASS_A;
    case (op)
      OP_ADD:  res = ALU_ADD;
      OP_SUB:  res = ALU_SUB;
      OP_AND:  res = ALU_AND;
      OP_OR:   res = ALU_OR;
      OP_XOR:  res = ALU_XOR;
      OP_CMP:  res = ALU_SUB;
      default: res = ALU_PASS_A;
    endcase
    return res;
  endfunction

  function automatic logic is_write_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_LDI);
  endfunction

  function automatic logic updates_zflag(input logic [3:0] op);
    return ((op >= OP_ADD) && (op <= OP_MOV)) || (op == OP_CMP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_unit: FETCH/EXEC/WB sequencer driving register-file selects,  |
// | write enable, ALU op and data-in mux from a combinational ROM.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module control_unit
  import proc_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [15:0]     instr,
  input  logic            zero,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      srd,
  output logic            le,
  output logic [3:0]      sba,
  output logic [3:0]      sbb,
  output logic [2:0]      alu_op,
  output logic [7:0]      imm,
  output logic            di_sel,
  output logic            halted
);

  ctrl_state_t     state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            zflag_q, zflag_d;

  logic [3:0] op;
  logic [3:0] rd;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [7:0] imm8;

  assign op   = ir_q[15:12];
  assign rd   = ir_q[11:8];
  assign ra   = ir_q[7:4];
  assign rb   = ir_q[3:0];
  assign imm8 = ir_q[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zflag_q <= zflag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    zflag_d = zflag_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = instr;
        pc_d    = pc_q + PC_W'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (updates_zflag(op)) zflag_d = zero;
        // A taken branch replaces the increment done in FETCH, so the
        // target is the very next address fetched.
        if ((op == OP_JMP) || ((op == OP_JZ) && zflag_q)) pc_d = PC_W'(imm8);
        state_d = (op == OP_HLT) ? ST_HALT : ST_WB;
      end
      ST_WB: begin
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs depend only on registered state and ir, never on inputs.
  always_comb begin
    srd    = 4'h0;
    le     = 1'b0;
    sba    = 4'h0;
    sbb    = 4'h0;
    alu_op = ALU_PASS_A;
    imm    = 8'h00;
    di_sel = 1'b0;
    halted = 1'b0;
    case (state_q)
      ST_EXEC: begin
        sba    = ra;
        sbb    = rb;
        alu_op = alu_decode(op);
        imm    = imm8;
      end
      ST_WB: begin
        sba    = ra;
        sbb    = rb;
        alu_op = alu_decode(op);
        imm    = imm8;
        if (is_write_op(op)) begin
          le     = 1'b1;
          srd    = rd;
          di_sel = (op == OP_LDI);
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_control_unit: scenario tasks against a ROM model, with expected    |
// | register writes queued up front and popped on each le pulse.          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_control_unit;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        zero;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic [3:0]  srd, sba, sbb;
  logic        le, di_sel, halted;
  logic [2:0]  alu_op;
  logic [7:0]  imm;

  logic [15:0] rom [0:255];

  typedef struct packed {
    logic [3:0] srd;
    logic       di_sel;
    logic [7:0] imm;
  } wr_t;

  wr_t exp_q[$];
  wr_t got, want;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign instr = rom[pc];

  control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .instr  (instr),
    .zero   (zero),
    .pc     (pc),
    .srd    (srd),
    .le     (le),
    .sba    (sba),
    .sbb    (sbb),
    .alu_op (alu_op),
    .imm    (imm),
    .di_sel (di_sel),
    .halted (halted)
  );

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  // Reset, release with run=1, and return sampling cycle 1 (FETCH of pc 0).
  task automatic begin_run();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    zero  = 1'b0;
    clear_rom();
    #12;
    checks++;
    if ({srd, le, sba, sbb, alu_op, imm, di_sel, halted} !== 29'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", {srd, le, sba, sbb, alu_op, imm, di_sel, halted});
    end
    checks++;
    if (pc !== 8'h00) begin
      errors++;
      $display("FAIL reset_pc: got %h, required 00", pc);
    end

    rom[0] = 16'h7105;
    rom[1] = 16'hF000;
    begin_run();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (le !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_wb_le: got %b, required 1", le);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({srd, le, sba, sbb, alu_op, imm, di_sel, halted} !== 29'h0) begin
      errors++;
      $display("FAIL reset_async_outputs: got %h, required 0", {srd, le, sba, sbb, alu_op, imm, di_sel, halted});
    end
    checks++;
    if (pc !== 8'h00) begin
      errors++;
      $display("FAIL reset_async_pc: got %h, required 00", pc);
    end
    @(negedge clk);
    run   = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({pc, le} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_release_fetch: pc/le got %h/%b, required 00/0", pc, le);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({pc, sbb} !== {8'h01, 4'h5}) begin
      errors++;
      $display("FAIL reset_release_exec: pc/sbb got %h/%h, required 01/5", pc, sbb);
    end
  endtask

  task automatic test_ldi();
    clear_rom();
    rom[0] = 16'h7105;
    rom[1] = 16'hF000;
    exp_q.push_back({4'd1, 1'b1, 8'h05});
    begin_run();
    checks++;
    if ({le, pc} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL ldi_c1: le/pc got %b/%h, required 0/00", le, pc);
    end
    @(negedge clk);
    checks++;
    if ({le, pc} !== {1'b0, 8'h01}) begin
      errors++;
      $display("FAIL ldi_c2: le/pc got %b/%h, required 0/01", le, pc);
    end
    @(negedge clk);
    checks++;
    if (le !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL ldi_wb_le: le=%b queued=%0d, required le=1 with a queued write", le, exp_q.size());
    end else begin
      want = exp_q.pop_front();
      got  = {srd, di_sel, imm};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL ldi_wb_write: srd/di_sel/imm got %h, required %h", got, want);
      end
    end
    @(negedge clk);
    checks++;
    if ({le, pc} !== {1'b0, 8'h01}) begin
      errors++;
      $display("FAIL ldi_c4: le/pc got %b/%h, required 0/01", le, pc);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL ldi_then_halt: halted got %b, required 1", halted);
    end
  endtask

  task automatic test_add();
    clear_rom();
    rom[0] = 16'h1312;
    rom[1] = 16'hF000;
    exp_q.push_back({4'd3, 1'b0, 8'h12});
    begin_run();
    @(negedge clk);
    checks++;
    if ({sba, sbb, alu_op, le} !== {4'h1, 4'h2, ALU_ADD, 1'b0}) begin
      errors++;
      $display("FAIL add_exec: sba/sbb/alu_op/le got %h/%h/%0d/%b, required 1/2/1/0", sba, sbb, alu_op, le);
    end
    @(negedge clk);
    checks++;
    if ({sba, sbb, alu_op} !== {4'h1, 4'h2, ALU_ADD}) begin
      errors++;
      $display("FAIL add_wb_hold: sba/sbb/alu_op got %h/%h/%0d, required 1/2/1", sba, sbb, alu_op);
    end
    checks++;
    if (le !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL add_wb_le: le=%b queued=%0d, required le=1 with a queued write", le, exp_q.size());
    end else begin
      want = exp_q.pop_front();
      got  = {srd, di_sel, imm};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL add_wb_write: srd/di_sel/imm got %h, required %h", got, want);
      end
    end
  endtask

  task automatic test_jz(input logic z, input logic [7:0] exp_pc);
    logic any_le;
    clear_rom();
    rom[0]     = 16'hA011;
    rom[1]     = 16'h9040;
    rom[2]     = 16'hF000;
    rom[8'h40] = 16'hF000;
    zero   = z;
    any_le = 1'b0;
    begin_run();
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      if (le === 1'b1) any_le = 1'b1;
      if (c == 2) begin
        checks++;
        if (alu_op !== ALU_SUB) begin
          errors++;
          $display("FAIL jz_cmp_aluop: got %0d, required 2", alu_op);
        end
      end
    end
    checks++;
    if (any_le !== 1'b0) begin
      errors++;
      $display("FAIL jz_no_write: le pulse seen=%b, required 0", any_le);
    end
    @(negedge clk);
    checks++;
    if (pc !== exp_pc) begin
      errors++;
      $display("FAIL jz_target zero=%b: pc got %h, required %h", z, pc, exp_pc);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL jz_halt zero=%b: halted got %b, required 1", z, halted);
    end
    zero = 1'b0;
  endtask

  task automatic test_wrap();
    logic any_le;
    clear_rom();
    rom[0]     = 16'h80FF;
    rom[8'hFF] = 16'hB123;
    any_le = 1'b0;
    begin_run();
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clk);
      if (le === 1'b1) any_le = 1'b1;
      if (c == 4) begin
        checks++;
        if (pc !== 8'hFF) begin
          errors++;
          $display("FAIL wrap_jmp_target: pc got %h, required ff", pc);
        end
      end
      if (c == 5 || c == 7) begin
        checks++;
        if (pc !== 8'h00) begin
          errors++;
          $display("FAIL wrap_pc cycle %0d: pc got %h, required 00", c, pc);
        end
      end
    end
    checks++;
    if (any_le !== 1'b0) begin
      errors++;
      $display("FAIL wrap_illegal_nop: le pulse seen=%b, required 0", any_le);
    end
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0] = 16'hF000;
    begin_run();
    @(negedge clk);
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_exec: halted got %b, required 0", halted);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({halted, le, pc} !== {1'b1, 1'b0, 8'h01}) begin
        errors++;
        $display("FAIL halt_hold %0d: halted/le/pc got %b/%b/%h, required 1/0/01", c, halted, le, pc);
      end
      run = ~run;
    end
  endtask

  task automatic test_idle();
    clear_rom();
    rom[0] = 16'h7105;
    rom[1] = 16'h7277;
    exp_q.push_back({4'd1, 1'b1, 8'h05});
    exp_q.push_back({4'd2, 1'b1, 8'h77});
    begin_run();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (le !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL idle_wb1_le: le=%b queued=%0d, required le=1 with a queued write", le, exp_q.size());
    end else begin
      want = exp_q.pop_front();
      got  = {srd, di_sel, imm};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL idle_wb1_write: got %h, required %h", got, want);
      end
    end
    run = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({srd, le, sba, sbb, alu_op, imm, di_sel, halted, pc} !== {29'h0, 8'h01}) begin
        errors++;
        $display("FAIL idle_outputs %0d: got %h pc %h, required 0 pc 01", c, {srd, le, sba, sbb, alu_op, imm, di_sel, halted}, pc);
      end
    end
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (le !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL idle_wb2_le: le=%b queued=%0d, required le=1 with a queued write", le, exp_q.size());
    end else begin
      want = exp_q.pop_front();
      got  = {srd, di_sel, imm};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL idle_wb2_write: got %h, required %h", got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   pulses;
    logic prev_le;
    clear_rom();
    rom[0] = 16'h7105;
    rom[1] = 16'h7233;
    rom[2] = 16'h1312;
    rom[3] = 16'h6430;
    rom[4] = 16'h5D21;
    rom[5] = 16'h7AEE;
    rom[6] = 16'hF000;
    exp_q.push_back({4'd1,  1'b1, 8'h05});
    exp_q.push_back({4'd2,  1'b1, 8'h33});
    exp_q.push_back({4'd3,  1'b0, 8'h12});
    exp_q.push_back({4'd4,  1'b0, 8'h30});
    exp_q.push_back({4'd13, 1'b0, 8'h21});
    exp_q.push_back({4'd10, 1'b1, 8'hEE});
    pulses  = 0;
    prev_le = 1'b0;
    begin_run();
    for (int c = 1; c <= 22; c++) begin
      if (c > 1) @(negedge clk);
      if (le === 1'b1) begin
        pulses++;
        checks++;
        if (prev_le === 1'b1 || exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_le cycle %0d: prev_le=%b queued=%0d, required single pulse with a queued write", c, prev_le, exp_q.size());
        end else begin
          want = exp_q.pop_front();
          got  = {srd, di_sel, imm};
          checks++;
          if (got !== want) begin
            errors++;
            $display("FAIL b2b_write cycle %0d: got %h, required %h", c, got, want);
          end
        end
      end
      prev_le = le;
    end
    checks++;
    if (pulses != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d left=%0d, required 6 and 0", pulses, exp_q.size());
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL b2b_halt: halted got %b, required 1", halted);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add();
    test_jz(1'b1, 8'h40);
    test_jz(1'b0, 8'h02);
    test_wrap();
    test_halt();
    test_idle();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/control_unit.md
# control_unit

Single-clock sequencing controller for the 16 × 8-bit register file. It fetches 16-bit instructions from a combinational program ROM and drives the register file's write select, write enable and two read selects. It also drives the ALU operation and the data-in source mux. It sits between program memory and the register-file/ALU datapath, replacing the hand-driven SRD/LE/SBA/SBB inputs.

## Interface
- PC_W, default 8: program counter width; the ROM depth is 2^PC_W.
- RESET_PC, default 0: PC value loaded on reset.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  start/continue; sampled in IDLE and at the end of WB.
- instr  in  16  ROM data for address pc, valid in the same cycle.
- zero  in  1  ALU result-is-zero flag, valid during EXEC.
- pc  out  PC_W  program counter; also the ROM address.
- srd  out  4  register-file write select.
- le  out  1  register-file write enable.
- sba, sbb  out  4 each  read-port A and read-port B selects.
- alu_op  out  3  ALU operation code.
- imm  out  8  immediate, ir[7:0].
- di_sel  out  1  register-file data source: 0 = ALU result, 1 = imm.
- halted  out  1  high while in HALT.

## Operation
- Instruction format: op = ir[15:12], rd = ir[11:8], ra = ir[7:4], rb = ir[3:0], imm8 = ir[7:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd ← ra op rb.
  - 6 MOV: rd ← ra, using the ALU pass-A op.
  - 7 LDI: rd ← imm8.
  - 8 JMP: pc ← imm8.
  - 9 JZ: pc ← imm8 if zflag.
  - A CMP: SUB with no write; updates zflag only.
  - F HLT.
  - B–E are illegal and execute as NOP.
- alu_op encodings: PASS_A=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5.
- FSM states: IDLE, FETCH, EXEC, WB, HALT.
  - IDLE: all outputs 0. If run=1, go to FETCH.
  - FETCH: ir ← instr; pc ← pc+1, wrapping modulo 2^PC_W. Go to EXEC.
  - EXEC:
    - sba = ra, sbb = rb, alu_op decoded.
    - ALU ops and CMP: zflag ← zero at the end of the cycle.
    - JMP: pc ← imm8, overriding the FETCH increment.
    - JZ: pc ← imm8 only if zflag (the value from the last ALU/CMP).
    - HLT: go to HALT. All other opcodes go to WB.
  - WB:
    - sba, sbb and alu_op are held at their EXEC values.
    - Write-class ops (1–7) assert le=1, srd=rd, and di_sel = (op==LDI).
    - All other ops keep le=0 and srd=0.
    - Exit: run=1 → FETCH; run=0 → IDLE.
  - HALT: halted=1, le=0. Only rst_n leaves this state.
- Outputs are decoded combinationally from the registered state and ir only; no input-to-output combinational path exists except none.
- le is high for exactly one cycle per write instruction.
- Writes to indices 10 (PIN), 14 (Xh), 11 (POUT), 12 (RcTimer) and 13 (Timer) are issued like any other index; the controller does not special-case them.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, pc = RESET_PC, ir = 0, zflag = 0.
  - srd, sba, sbb, alu_op, imm = 0; le, di_sel, halted = 0.
- Every executed instruction takes 3 cycles: FETCH, EXEC, WB. HLT takes 2 (FETCH, EXEC).
- The first FETCH is the cycle after run is sampled high in IDLE.
- A jump target is fetched in the FETCH that follows WB; there is no delay slot.
- zflag written in EXEC of instruction N is visible to a JZ at N+1.
- PC wrap: FETCH at pc = 2^PC_W−1 sets pc = 0.
- rst_n asserted in any state, including mid-WB: le drops immediately and no write is issued.

## Structure
- Package proc_pkg holds:
  - opcode_t enum (4-bit).
  - ctrl_state_t enum.
  - alu_op_t enum (3-bit).
  - Register index constants REG_PIN=10, REG_POUT=11, REG_RCTIMER=12, REG_TIMER=13, REG_XH=14, REG_XL=15.
- Single module; no sub-module. The decode is a combinational always_comb block beside the FSM/PC always_ff.

## Test plan
- Reset: drop rst_n mid-stream → all outputs 0 and pc = 0 asynchronously; release with run=1 → FETCH on the next edge.
- LDI: program 0x7105 → in WB cycle 3, le=1, srd=1, imm=0x05, di_sel=1; le=0 in cycles 1–2 and 4.
- ADD: program 0x1312 → EXEC sba=1, sbb=2, alu_op=ADD; WB le=1, srd=3, di_sel=0.
- Zero flag and JZ:
  - CMP 0xA011 with zero=1, then JZ 0x9040 → pc=0x40 at the next FETCH; no le pulse for CMP.
  - Repeat with zero=0 → pc continues sequentially.
- PC wrap: pc = 0xFF executing NOP → next fetch address 0x00.
- Halt and run: HLT 0xF000 → halted=1 from the cycle after EXEC and held with run toggling; run=0 at WB of any instruction → IDLE with all outputs 0.
